// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: stall-cause bit
// positions, slot-field width helper and the default-geometry slot layout.
package hazard_pkg;

    localparam int CAUSE_LOAD  = 0;
    localparam int CAUSE_EARLY = 1;
    localparam int CAUSE_MD    = 2;
    localparam int CAUSE_W     = 3;

    localparam int DEF_RW_W  = 5;
    localparam int DEF_REM_W = 2;

    // Bits needed to hold a remaining-latency count of up to lat.
    function automatic int rem_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [DEF_RW_W-1:0]  rw;
        logic [DEF_REM_W-1:0] rem;
    } sb_slot_t;

endpackage

// File: rtl/md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit: loads on start, counts
// down, and pulses done for one cycle on a natural 1 -> 0 transition.
module md_busy_counter #(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic kill,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(MD_LAT + 1);

    logic [CW-1:0] count;
    logic          done_q;

    // kill beats start; a restart on the final cycle suppresses the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= !kill && !start && (count == CW'(1));
            if (kill) begin
                count <= '0;
            end else if (start) begin
                count <= CW'(MD_LAT);
            end else if (count != '0) begin
                count <= count - CW'(1);
            end
        end
    end

    assign busy = (count != '0);
    assign done = done_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall detector: shift-register scoreboard of in-flight register
// writes with per-slot remaining latency, plus the MD unit busy tracker.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG_AW  = 5,
    parameter int DEPTH    = 2,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MD_LAT   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREG_AW-1:0]           id_rs,
    input  logic [NREG_AW-1:0]           id_rt,
    input  logic                         id_use_rs,
    input  logic                         id_use_rt,
    input  logic                         id_early,
    input  logic                         id_md_use,
    input  logic                         issue,
    input  logic [NREG_AW-1:0]           issue_rw,
    input  logic                         issue_regwrite,
    input  logic                         issue_load,
    input  logic                         issue_md_start,
    input  logic [DEPTH-1:0]             flush_mask,
    input  logic                         md_kill,
    output logic                         stall,
    output logic [2:0]                   stall_cause,
    output logic                         md_busy,
    output logic                         md_done,
    output logic [$clog2(DEPTH+1)-1:0]   inflight
);

    localparam int REM_W = rem_width(LOAD_LAT);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic               valid;
        logic [NREG_AW-1:0] rw;
        logic [REM_W-1:0]   rem;
    } slot_t;

    if (!(DEPTH >= LOAD_LAT && LOAD_LAT >= ALU_LAT && ALU_LAT >= 1)) begin : g_bad_params
        $error("hazard_scoreboard: need DEPTH >= LOAD_LAT >= ALU_LAT >= 1");
    end

    slot_t slots [DEPTH];
    slot_t new_slot;
    logic  eff_issue;

    // The oldest slot always leaves the table, so its flush bit has nothing to kill.
    logic unused_last_flush;
    assign unused_last_flush = flush_mask[DEPTH-1];

    // One cycle of ageing: a slot survives only if it is not flushed and
    // still has latency left after this edge.
    function automatic slot_t age_slot(input slot_t s, input logic kill);
        slot_t r;
        r = '0;
        if (s.valid && !kill && (s.rem > REM_W'(1))) begin
            r.valid = 1'b1;
            r.rw    = s.rw;
            r.rem   = s.rem - REM_W'(1);
        end
        return r;
    endfunction

    // An instruction moves ID -> EX only when issue is high and no stall is
    // raised in the same cycle; an issue during a stall has no effect.
    assign eff_issue = issue && !stall;

    always_comb begin
        new_slot = '0;
        if (eff_issue && issue_regwrite && (issue_rw != '0)) begin
            new_slot.valid = 1'b1;
            new_slot.rw    = issue_rw;
            new_slot.rem   = issue_load ? REM_W'(LOAD_LAT) : REM_W'(ALU_LAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= age_slot(slots[k-1], flush_mask[k-1]);
            end
            slots[0] <= new_slot;
        end
    end

    // Scan oldest to youngest so the youngest matching write wins.
    logic [REM_W-1:0] rs_rem;
    logic [REM_W-1:0] rt_rem;

    always_comb begin
        rs_rem = '0;
        rt_rem = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slots[k].valid && (slots[k].rw == id_rs)) begin
                rs_rem = slots[k].rem;
            end
            if (slots[k].valid && (slots[k].rw == id_rt)) begin
                rt_rem = slots[k].rem;
            end
        end
    end

    logic rs_used;
    logic rt_used;
    assign rs_used = id_use_rs && (id_rs != '0);
    assign rt_used = id_use_rt && (id_rt != '0);

    always_comb begin
        stall_cause = '0;
        stall_cause[CAUSE_LOAD] = !id_early &&
            ((rs_used && (rs_rem > REM_W'(1))) || (rt_used && (rt_rem > REM_W'(1))));
        stall_cause[CAUSE_EARLY] = id_early &&
            ((rs_used && (rs_rem != '0)) || (rt_used && (rt_rem != '0)));
        stall_cause[CAUSE_MD] = id_md_use && md_busy;
    end

    assign stall = |stall_cause;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight = inflight + CNT_W'(slots[k].valid);
        end
    end

    md_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (eff_issue && issue_md_start),
        .kill  (md_kill),
        .busy  (md_busy),
        .done  (md_done)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed legacy-hazard scenarios followed by
// random traffic, checked against a timestamp-based model of in-flight writes.
module tb_hazard_scoreboard;

    localparam int NREG_AW  = 5;
    localparam int DEPTH    = 2;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;
    localparam int MD_LAT   = 4;

    logic               clk;
    logic               rst_n;
    logic [NREG_AW-1:0] id_rs;
    logic [NREG_AW-1:0] id_rt;
    logic               id_use_rs;
    logic               id_use_rt;
    logic               id_early;
    logic               id_md_use;
    logic               issue;
    logic [NREG_AW-1:0] issue_rw;
    logic               issue_regwrite;
    logic               issue_load;
    logic               issue_md_start;
    logic [DEPTH-1:0]   flush_mask;
    logic               md_kill;
    logic               stall;
    logic [2:0]         stall_cause;
    logic               md_busy;
    logic               md_done;
    logic [1:0]         inflight;

    hazard_scoreboard #(
        .NREG_AW  (NREG_AW),
        .DEPTH    (DEPTH),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT),
        .MD_LAT   (MD_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_early       (id_early),
        .id_md_use      (id_md_use),
        .issue          (issue),
        .issue_rw       (issue_rw),
        .issue_regwrite (issue_regwrite),
        .issue_load     (issue_load),
        .issue_md_start (issue_md_start),
        .flush_mask     (flush_mask),
        .md_kill        (md_kill),
        .stall          (stall),
        .stall_cause    (stall_cause),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .inflight       (inflight)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ignored_issues = 0;

    // Reference model: each write is remembered by the cycle it entered EX;
    // its remaining latency is its nominal latency minus its age.
    typedef struct {
        int rg;
        int issued;
        int lat;
        bit killed;
    } wr_t;

    wr_t wq[$];
    int  cyc         = 0;
    int  md_until    = -1;
    int  md_done_at  = -1;
    logic last_stall = 1'b0;
    logic last_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_rem(input int r);
        int best = -1;
        int rem  = 0;
        foreach (wq[i]) begin
            if (wq[i].rg == r && wq[i].issued > best) begin
                best = wq[i].issued;
                rem  = wq[i].lat - (cyc - wq[i].issued);
            end
        end
        return rem;
    endfunction

    task automatic clr_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_early = 1'b0; id_md_use = 1'b0; issue = 1'b0; issue_rw = '0;
        issue_regwrite = 1'b0; issue_load = 1'b0; issue_md_start = 1'b0;
        flush_mask = '0; md_kill = 1'b0;
    endtask

    task automatic model_reset();
        wq.delete();
        md_until   = -1;
        md_done_at = -1;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the
    // model across the rising edge using the same inputs the DUT sampled.
    task automatic cycle(input string tag);
        int   rem_v;
        int   idx;
        logic ld;
        logic er;
        logic md;
        logic exp_stall;
        bit   eff;
        wr_t  keep[$];
        @(negedge clk);
        ld = 1'b0;
        er = 1'b0;
        if (id_use_rs && id_rs != 0) begin
            rem_v = model_rem(int'(id_rs));
            if (id_early) er = er | (rem_v > 0); else ld = ld | (rem_v > 1);
        end
        if (id_use_rt && id_rt != 0) begin
            rem_v = model_rem(int'(id_rt));
            if (id_early) er = er | (rem_v > 0); else ld = ld | (rem_v > 1);
        end
        md = id_md_use && (cyc < md_until);
        exp_stall = ld | er | md;
        check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        check({tag, "_cause"}, 32'(stall_cause), 32'({md, er, ld}));
        check({tag, "_md_busy"}, 32'(md_busy), 32'(cyc < md_until));
        check({tag, "_md_done"}, 32'(md_done), 32'(cyc == md_done_at));
        check({tag, "_inflight"}, 32'(inflight), 32'(wq.size()));
        last_stall = stall;
        last_done  = md_done;
        @(posedge clk);
        eff = (issue === 1'b1) && !exp_stall;
        if (issue === 1'b1 && exp_stall) ignored_issues++;
        foreach (wq[i]) begin
            idx = cyc - wq[i].issued;
            if (idx < DEPTH && ((int'(flush_mask) >> idx) & 1) == 1) wq[i].killed = 1'b1;
        end
        if (md_kill) begin
            md_until   = -1;
            md_done_at = -1;
        end else if (eff && issue_md_start) begin
            md_until   = cyc + 1 + MD_LAT;
            md_done_at = md_until;
        end
        if (eff && issue_regwrite && issue_rw != 0)
            wq.push_back('{int'(issue_rw), cyc + 1, issue_load ? LOAD_LAT : ALU_LAT, 1'b0});
        cyc++;
        foreach (wq[i])
            if (!wq[i].killed && (wq[i].lat - (cyc - wq[i].issued)) > 0) keep.push_back(wq[i]);
        wq = keep;
        #1;
    endtask

    // Hold the current ID instruction until it is no longer stalled and
    // compare the number of bubbles with the architectural expectation.
    task automatic run_consumer(input string tag, input int exp_bubbles);
        int n    = 0;
        bit left = 1'b0;
        for (int i = 0; i < 8 && !left; i++) begin
            cycle(tag);
            if (last_stall === 1'b1) n++; else left = 1'b1;
        end
        check({tag, "_bubbles"}, 32'(n), 32'(exp_bubbles));
        clr_inputs();
    endtask

    task automatic issue_write(input string tag, input int rw, input bit load);
        clr_inputs();
        issue = 1'b1; issue_regwrite = 1'b1; issue_rw = NREG_AW'(rw); issue_load = load;
        cycle(tag);
        clr_inputs();
    endtask

    task automatic idle(input int n);
        clr_inputs();
        for (int i = 0; i < n; i++) cycle("idle");
    endtask

    initial begin
        int done_cnt;
        clr_inputs();
        rst_n = 1'b0;
        id_rs = 5'd3; id_use_rs = 1'b1;
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_cause", 32'(stall_cause), 32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_md_done", 32'(md_done), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("idle_rs3");

        // Load-use: one bubble for a normal consumer, two for an early one.
        issue_write("ld5", 5, 1'b1);
        issue = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
        run_consumer("load_use", 1);
        idle(2);
        issue_write("ld5e", 5, 1'b1);
        issue = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1; id_early = 1'b1;
        run_consumer("load_branch", 2);
        idle(2);

        // ALU producer: branch costs one bubble, normal consumer none, r0 never.
        issue_write("alu7", 7, 1'b0);
        issue = 1'b1; id_rt = 5'd7; id_use_rt = 1'b1; id_early = 1'b1;
        run_consumer("alu_branch", 1);
        idle(2);
        issue_write("alu7n", 7, 1'b0);
        issue = 1'b1; id_rt = 5'd7; id_use_rt = 1'b1;
        run_consumer("alu_use", 0);
        issue_write("alu0", 0, 1'b1);
        issue = 1'b1; id_rs = 5'd0; id_use_rs = 1'b1; id_early = 1'b1;
        run_consumer("r0_use", 0);
        idle(2);

        // Newer ALU write to r9 shadows the older load of r9.
        issue_write("ld9", 9, 1'b1);
        issue_write("alu9", 9, 1'b0);
        issue = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
        run_consumer("shadow", 0);
        idle(2);

        // Flush kills the load one edge after it enters EX.
        issue_write("ld4", 4, 1'b1);
        flush_mask = 2'b01;
        cycle("flush01");
        clr_inputs();
        issue = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1; id_early = 1'b1;
        run_consumer("flushed_use", 0);
        check("flushed_inflight", 32'(inflight), 32'd0);

        // Flush of the old slot0 does not affect a load issued on the same edge.
        issue_write("alu6", 6, 1'b0);
        issue = 1'b1; issue_regwrite = 1'b1; issue_rw = 5'd4; issue_load = 1'b1;
        flush_mask = 2'b01;
        cycle("flush_issue");
        clr_inputs();
        check("flush_issue_inflight", 32'(inflight), 32'd1);
        issue = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1;
        run_consumer("flush_issue_use", 1);
        idle(2);

        // MD: four busy cycles, done pulse when it drains.
        clr_inputs();
        issue = 1'b1; issue_md_start = 1'b1;
        cycle("md_start");
        clr_inputs();
        issue = 1'b1; id_md_use = 1'b1;
        run_consumer("md_use", 4);
        check("md_done_pulse", 32'(last_done), 32'd1);
        idle(2);

        // MD kill on the second busy cycle: no done pulse follows.
        issue = 1'b1; issue_md_start = 1'b1;
        cycle("md_start2");
        clr_inputs();
        cycle("md_busy1");
        md_kill = 1'b1;
        cycle("md_kill");
        clr_inputs();
        check("md_kill_busy", 32'(md_busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("md_after_kill");
            done_cnt += int'(last_done);
        end
        check("md_kill_no_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset in the middle of a stall.
        issue_write("ld5r", 5, 1'b1);
        issue = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
        @(negedge clk);
        check("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_inflight", 32'(inflight), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        clr_inputs();
        @(posedge clk);
        cyc++;
        #1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            issue          = ($urandom_range(0, 3) != 0);
            issue_regwrite = ($urandom_range(0, 3) != 0);
            issue_load     = 1'($urandom_range(0, 1));
            issue_rw       = NREG_AW'($urandom_range(0, 7));
            issue_md_start = ($urandom_range(0, 15) == 0);
            md_kill        = ($urandom_range(0, 31) == 0);
            flush_mask     = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom_range(0, 3)) : '0;
            id_rs          = NREG_AW'($urandom_range(0, 7));
            id_rt          = NREG_AW'($urandom_range(0, 7));
            id_use_rs      = 1'($urandom_range(0, 1));
            id_use_rt      = 1'($urandom_range(0, 1));
            id_early       = ($urandom_range(0, 3) == 0);
            id_md_use      = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("note: %0d issue requests arrived during a stall and were held", ignored_issues);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
